// File: rtl/l2c_fill_q.sv
// L2C fill controller: queues MNI fill requests and sequences each one through tag check,
// writeback wait, SRAM access and tag set, demoting repeatedly failing lines to direct transfers.
module l2c_fill_q #(
  parameter int unsigned WAY_BITS  = 3,
  parameter int unsigned SET_BITS  = 9,
  parameter int unsigned LINE_BITS = 6,
  parameter int unsigned QDEPTH    = 2,
  parameter int unsigned MAX_RETRY = 7
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   i_mni_fill_valid,
  input  logic [3:0]                             i_mni_fill_len,
  input  logic [31:0]                            i_mni_fill_adr,
  output logic                                   o_mni_fill_ready,
  input  logic                                   i_fill_success,
  input  logic                                   i_fill_fail,
  input  logic [WAY_BITS-1:0]                    i_way,
  output logic                                   o_fill_check_req,
  output logic                                   o_fill_set_req,
  output logic [31:0]                            o_fill_adr,
  output logic [WAY_BITS-1:0]                    o_fill_set_way,
  input  logic                                   i_wb_ack_broadcast,
  input  logic                                   i_fill_start,
  input  logic                                   i_fill_end,
  output logic [SET_BITS+WAY_BITS+LINE_BITS-1:0] o_sram_adr,
  output logic                                   o_mni_fill_stall,
  output logic                                   o_fill_direct,
  output logic                                   o_fill_broadcast,
  output logic                                   o_fill_abort,
  output logic                                   o_busy
);

  localparam int unsigned PtrW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned RetryW = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [6:0] {
    StIdle      = 7'b000_0001,
    StTagCheck  = 7'b000_0010,
    StWaitWbAck = 7'b000_0100,
    StSram      = 7'b000_1000,
    StAccess    = 7'b001_0000,
    StTagSet    = 7'b010_0000,
    StDirect    = 7'b100_0000
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]         q_adr_q [QDEPTH];
  logic [31:0]         q_adr_d [QDEPTH];
  logic [3:0]          q_len_q [QDEPTH];
  logic [3:0]          q_len_d [QDEPTH];
  logic [RetryW-1:0]   retry_q, retry_d, retry_inc;
  logic [WAY_BITS-1:0] way_q, way_d;
  logic [31:0]         fill_adr_q, fill_adr_d;
  logic                full, empty, push, pop, abort;
  logic [PtrW-1:0]     wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[PtrW-1:0];
  assign rd_idx = rd_ptr_q[PtrW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);
  assign push   = i_mni_fill_valid & ~full;
  assign pop    = (state_q == StIdle) & ~empty;

  // Saturating so an unlimited retry budget never wraps back to a small count.
  assign retry_inc = (&retry_q) ? retry_q : retry_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_adr_d    = q_adr_q;
    q_len_d    = q_len_q;
    retry_d    = retry_q;
    way_d      = way_q;
    fill_adr_d = fill_adr_q;
    abort      = 1'b0;

    if (push) begin
      q_adr_d[wr_idx] = i_mni_fill_adr;
      q_len_d[wr_idx] = i_mni_fill_len;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          rd_ptr_d   = rd_ptr_q + 1'b1;
          fill_adr_d = q_adr_q[rd_idx];
          retry_d    = '0;
          state_d    = (q_len_q[rd_idx] == 4'd0) ? StDirect : StTagCheck;
        end
      end
      StTagCheck: begin
        if (i_fill_fail) begin
          retry_d = retry_inc;
          if ((MAX_RETRY != 0) && (retry_inc == RetryW'(MAX_RETRY))) begin
            state_d = StDirect;
            abort   = 1'b1;
          end else begin
            state_d = StWaitWbAck;
          end
        end else if (i_fill_success) begin
          way_d   = i_way;
          state_d = StSram;
        end
      end
      StWaitWbAck: if (i_wb_ack_broadcast) state_d = StTagCheck;
      StSram:      if (i_fill_start) state_d = StAccess;
      StAccess:    if (i_fill_end) state_d = StTagSet;
      StTagSet:    if (i_fill_success) state_d = StIdle;
      StDirect:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      retry_q    <= '0;
      way_q      <= '0;
      fill_adr_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_adr_q[i] <= '0;
        q_len_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      retry_q    <= retry_d;
      way_q      <= way_d;
      fill_adr_q <= fill_adr_d;
      q_adr_q    <= q_adr_d;
      q_len_q    <= q_len_d;
    end
  end

  assign o_mni_fill_ready = ~full;
  assign o_fill_check_req = (state_q == StTagCheck);
  assign o_fill_set_req   = (state_q == StTagSet);
  assign o_fill_broadcast = (state_q == StTagSet) & i_fill_success;
  assign o_fill_direct    = (state_q == StDirect);
  assign o_fill_abort     = abort;
  assign o_mni_fill_stall = ~(((state_q == StSram) & i_fill_start) | (state_q == StAccess) |
                              (state_q == StDirect));
  assign o_busy           = (state_q != StIdle) | ~empty;
  assign o_fill_adr       = fill_adr_q;
  assign o_fill_set_way   = way_q;
  assign o_sram_adr       = {fill_adr_q[LINE_BITS+SET_BITS-1:LINE_BITS], way_q,
                             {LINE_BITS{1'b0}}};

endmodule

// File: tb/tb_l2c_fill_q.sv
// Directed bench for l2c_fill_q: per-cycle vector table plus hand sequences for the
// retry-limit demotion (second instance with MAX_RETRY=2) and SRAM address formation.
module tb_l2c_fill_q;

  logic        Clk, Reset;
  logic        i_mni_fill_valid, i_fill_success, i_fill_fail, i_wb_ack_broadcast;
  logic        i_fill_start, i_fill_end;
  logic [3:0]  i_mni_fill_len;
  logic [31:0] i_mni_fill_adr;
  logic [2:0]  i_way;

  logic        ready, chk_req, set_req, direct, bcast, abort, stall, busy;
  logic [31:0] fill_adr;
  logic [2:0]  set_way;
  logic [17:0] sram_adr;

  logic        r2_ready, r2_chk, r2_set, r2_direct, r2_bcast, r2_abort, r2_stall, r2_busy;
  logic [31:0] r2_adr;
  logic [2:0]  r2_way;
  logic [17:0] r2_sram;

  int n_cmp = 0;
  int n_err = 0;

  l2c_fill_q dut (
    .Clk(Clk), .Reset(Reset),
    .i_mni_fill_valid(i_mni_fill_valid), .i_mni_fill_len(i_mni_fill_len),
    .i_mni_fill_adr(i_mni_fill_adr), .o_mni_fill_ready(ready),
    .i_fill_success(i_fill_success), .i_fill_fail(i_fill_fail), .i_way(i_way),
    .o_fill_check_req(chk_req), .o_fill_set_req(set_req), .o_fill_adr(fill_adr),
    .o_fill_set_way(set_way), .i_wb_ack_broadcast(i_wb_ack_broadcast),
    .i_fill_start(i_fill_start), .i_fill_end(i_fill_end), .o_sram_adr(sram_adr),
    .o_mni_fill_stall(stall), .o_fill_direct(direct), .o_fill_broadcast(bcast),
    .o_fill_abort(abort), .o_busy(busy)
  );

  l2c_fill_q #(.MAX_RETRY(2)) dut_r2 (
    .Clk(Clk), .Reset(Reset),
    .i_mni_fill_valid(i_mni_fill_valid), .i_mni_fill_len(i_mni_fill_len),
    .i_mni_fill_adr(i_mni_fill_adr), .o_mni_fill_ready(r2_ready),
    .i_fill_success(i_fill_success), .i_fill_fail(i_fill_fail), .i_way(i_way),
    .o_fill_check_req(r2_chk), .o_fill_set_req(r2_set), .o_fill_adr(r2_adr),
    .o_fill_set_way(r2_way), .i_wb_ack_broadcast(i_wb_ack_broadcast),
    .i_fill_start(i_fill_start), .i_fill_end(i_fill_end), .o_sram_adr(r2_sram),
    .o_mni_fill_stall(r2_stall), .o_fill_direct(r2_direct), .o_fill_broadcast(r2_bcast),
    .o_fill_abort(r2_abort), .o_busy(r2_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ctl = {rst, valid, success, fail, wb_ack, start, end}
  // exp = {ready, check_req, set_req, direct, broadcast, abort, stall, busy}
  typedef struct {
    logic [6:0]  ctl;
    logic [3:0]  len;
    logic [31:0] adr;
    logic [2:0]  way;
    logic [7:0]  exp;
    logic [31:0] exp_adr;
    logic [2:0]  exp_way;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [6:0] ctl, logic [3:0] len, logic [31:0] adr,
                              logic [2:0] way, logic [7:0] exp, logic [31:0] ea,
                              logic [2:0] ew);
    vec_t v;
    v.ctl = ctl; v.len = len; v.adr = adr; v.way = way;
    v.exp = exp; v.exp_adr = ea; v.exp_way = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [6:0] ctl, input logic [3:0] len, input logic [31:0] adr,
                       input logic [2:0] way);
    Reset              = ctl[6];
    i_mni_fill_valid   = ctl[5];
    i_fill_success     = ctl[4];
    i_fill_fail        = ctl[3];
    i_wb_ack_broadcast = ctl[2];
    i_fill_start       = ctl[1];
    i_fill_end         = ctl[0];
    i_mni_fill_len     = len;
    i_mni_fill_adr     = adr;
    i_way              = way;
    @(negedge Clk);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    apply(7'b1000000, 4'd0, 32'h0, 3'd0);
    tick();
    apply(7'b1000000, 4'd0, 32'h0, 3'd0);
    tick();
  endtask

  initial begin
    int nbc;
    logic [7:0] flags;

    // A: single len=4 fill at 0x1240 with way 5
    vecs.push_back(mk(7'b0100000, 4'd4, 32'h1240, 3'd0, 8'b1000_0010, 32'h0,    3'd0));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h0,    3'd0));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd5, 8'b1100_0011, 32'h1240, 3'd0));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h1240, 3'd5));
    vecs.push_back(mk(7'b0000010, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h1240, 3'd5));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h1240, 3'd5));
    vecs.push_back(mk(7'b0000001, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h1240, 3'd5));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1010_0011, 32'h1240, 3'd5));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd0, 8'b1010_1011, 32'h1240, 3'd5));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0010, 32'h1240, 3'd5));
    // B: len=0 direct transfer
    vecs.push_back(mk(7'b0100000, 4'd0, 32'h2000, 3'd0, 8'b1000_0010, 32'h1240, 3'd5));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h1240, 3'd5));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1001_0001, 32'h2000, 3'd5));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0010, 32'h2000, 3'd5));
    // C: two fails with writeback acks, then success; no abort at MAX_RETRY=7
    vecs.push_back(mk(7'b0100000, 4'd2, 32'h5080, 3'd0, 8'b1000_0010, 32'h2000, 3'd5));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h2000, 3'd5));
    vecs.push_back(mk(7'b0001000, 4'd0, 32'h0,    3'd0, 8'b1100_0011, 32'h5080, 3'd5));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h5080, 3'd5));
    vecs.push_back(mk(7'b0000100, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h5080, 3'd5));
    vecs.push_back(mk(7'b0001000, 4'd0, 32'h0,    3'd0, 8'b1100_0011, 32'h5080, 3'd5));
    vecs.push_back(mk(7'b0000100, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h5080, 3'd5));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd2, 8'b1100_0011, 32'h5080, 3'd5));
    vecs.push_back(mk(7'b0000010, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h5080, 3'd2));
    vecs.push_back(mk(7'b0000001, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h5080, 3'd2));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd0, 8'b1010_1011, 32'h5080, 3'd2));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0010, 32'h5080, 3'd2));
    // D: three back-to-back requests, a fourth refused while the queue is full
    vecs.push_back(mk(7'b0100000, 4'd1, 32'h1000, 3'd0, 8'b1000_0010, 32'h5080, 3'd2));
    vecs.push_back(mk(7'b0100000, 4'd2, 32'h2040, 3'd0, 8'b1000_0011, 32'h5080, 3'd2));
    vecs.push_back(mk(7'b0110000, 4'd3, 32'h3080, 3'd1, 8'b1100_0011, 32'h1000, 3'd2));
    vecs.push_back(mk(7'b0100010, 4'd1, 32'h4000, 3'd0, 8'b0000_0001, 32'h1000, 3'd1));
    vecs.push_back(mk(7'b0000001, 4'd0, 32'h0,    3'd0, 8'b0000_0001, 32'h1000, 3'd1));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd0, 8'b0010_1011, 32'h1000, 3'd1));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b0000_0011, 32'h1000, 3'd1));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd2, 8'b1100_0011, 32'h2040, 3'd1));
    vecs.push_back(mk(7'b0000010, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h2040, 3'd2));
    vecs.push_back(mk(7'b0000001, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h2040, 3'd2));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd0, 8'b1010_1011, 32'h2040, 3'd2));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h2040, 3'd2));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd3, 8'b1100_0011, 32'h3080, 3'd2));
    vecs.push_back(mk(7'b0000010, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h3080, 3'd3));
    vecs.push_back(mk(7'b0000001, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h3080, 3'd3));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd0, 8'b1010_1011, 32'h3080, 3'd3));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0010, 32'h3080, 3'd3));
    // E: fail+success together takes WaitWbAck; reset in Access flushes everything
    vecs.push_back(mk(7'b0100000, 4'd1, 32'h40,   3'd0, 8'b1000_0010, 32'h3080, 3'd3));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h3080, 3'd3));
    vecs.push_back(mk(7'b0011000, 4'd0, 32'h0,    3'd6, 8'b1100_0011, 32'h40,   3'd3));
    vecs.push_back(mk(7'b0000010, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h40,   3'd3));
    vecs.push_back(mk(7'b0000100, 4'd0, 32'h0,    3'd0, 8'b1000_0011, 32'h40,   3'd3));
    vecs.push_back(mk(7'b0010000, 4'd0, 32'h0,    3'd4, 8'b1100_0011, 32'h40,   3'd3));
    vecs.push_back(mk(7'b0000010, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h40,   3'd4));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0001, 32'h40,   3'd4));
    vecs.push_back(mk(7'b1100000, 4'd1, 32'h99c0, 3'd0, 8'b1000_0001, 32'h40,   3'd4));
    vecs.push_back(mk(7'b0000000, 4'd0, 32'h0,    3'd0, 8'b1000_0010, 32'h0,    3'd0));

    do_reset();
    apply(7'b0000000, 4'd0, 32'h0, 3'd0);
    flags = {ready, chk_req, set_req, direct, bcast, abort, stall, busy};
    chk("reset flags", {24'b0, flags}, 32'h82);
    chk("reset fill_adr", fill_adr, 32'h0);
    chk("reset set_way", {29'b0, set_way}, 32'h0);
    chk("reset sram_adr", {14'b0, sram_adr}, 32'h0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ctl, vecs[i].len, vecs[i].adr, vecs[i].way);
      flags = {ready, chk_req, set_req, direct, bcast, abort, stall, busy};
      chk($sformatf("vec%0d flags", i), {24'b0, flags}, {24'b0, vecs[i].exp});
      chk($sformatf("vec%0d fill_adr", i), fill_adr, vecs[i].exp_adr);
      chk($sformatf("vec%0d set_way", i), {29'b0, set_way}, {29'b0, vecs[i].exp_way});
      tick();
    end

    // F: SRAM address formation and a single broadcast per fill
    do_reset();
    nbc = 0;
    apply(7'b0100000, 4'd4, 32'h1240, 3'd0); nbc += int'(bcast); tick();
    apply(7'b0000000, 4'd0, 32'h0, 3'd0);    nbc += int'(bcast); tick();
    apply(7'b0010000, 4'd0, 32'h0, 3'd5);    nbc += int'(bcast); tick();
    apply(7'b0000000, 4'd0, 32'h0, 3'd0);    nbc += int'(bcast);
    chk("F sram_adr", {14'b0, sram_adr}, 32'h9340);
    chk("F set_way", {29'b0, set_way}, 32'h5);
    tick();
    apply(7'b0000010, 4'd0, 32'h0, 3'd0);    nbc += int'(bcast); tick();
    apply(7'b0000001, 4'd0, 32'h0, 3'd0);    nbc += int'(bcast); tick();
    apply(7'b0010000, 4'd0, 32'h0, 3'd0);    nbc += int'(bcast); tick();
    apply(7'b0000000, 4'd0, 32'h0, 3'd0);    nbc += int'(bcast);
    chk("F broadcast count", nbc, 32'd1);
    chk("F sram_adr hold", {14'b0, sram_adr}, 32'h9340);
    tick();

    // R: MAX_RETRY=2 instance, abort on second fail and retry count cleared per request
    do_reset();
    for (int r = 0; r < 2; r++) begin
      apply(7'b0100000, 4'd2, 32'h6000 + 32'h1000 * r, 3'd0);
      chk($sformatf("R%0d busy before push", r), {31'b0, r2_busy}, 32'd0);
      tick();
      apply(7'b0000000, 4'd0, 32'h0, 3'd0); tick();
      apply(7'b0001000, 4'd0, 32'h0, 3'd0);
      chk($sformatf("R%0d first fail check_req", r), {31'b0, r2_chk}, 32'd1);
      chk($sformatf("R%0d first fail abort", r), {31'b0, r2_abort}, 32'd0);
      tick();
      apply(7'b0000100, 4'd0, 32'h0, 3'd0); tick();
      apply(7'b0001000, 4'd0, 32'h0, 3'd0);
      chk($sformatf("R%0d second fail abort", r), {31'b0, r2_abort}, 32'd1);
      tick();
      apply(7'b0000000, 4'd0, 32'h0, 3'd0);
      chk($sformatf("R%0d direct", r), {31'b0, r2_direct}, 32'd1);
      chk($sformatf("R%0d direct stall", r), {31'b0, r2_stall}, 32'd0);
      chk($sformatf("R%0d direct abort", r), {31'b0, r2_abort}, 32'd0);
      tick();
      apply(7'b0000000, 4'd0, 32'h0, 3'd0);
      chk($sformatf("R%0d idle busy", r), {31'b0, r2_busy}, 32'd0);
      chk($sformatf("R%0d idle direct", r), {31'b0, r2_direct}, 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
